// File: rtl/logic_func_pipe.sv
// Multi-channel bitwise logic unit (AND/OR/XOR/MAJ) behind a 2-stage valid/ready pipeline.
// Optional output-transfer statistics counter enabled by defining LFP_STAT_EN.
package rtl_pkg;
    localparam int DW = 8;
endpackage

module logic_func_pipe #(
    parameter int DW   = rtl_pkg::DW,
    parameter int NCH  = 3,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data
`ifdef LFP_STAT_EN
    ,
    output logic [CNTW-1:0]   stat_cnt
`endif
);

    localparam logic [1:0] MODE_AND = 2'b00;
    localparam logic [1:0] MODE_OR  = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_MAJ = 2'b11;

    // Per bit position, count the ones across channels and derive all four functions from that count.
    function automatic logic [DW-1:0] lf_eval(input logic [NCH*DW-1:0] d, input logic [1:0] m);
        logic [DW-1:0] r;
        int            ones;
        r = '0;
        for (int i = 0; i < DW; i++) begin
            ones = 0;
            for (int k = 0; k < NCH; k++) begin
                ones = ones + int'(d[k*DW+i]);
            end
            case (m)
                MODE_AND: r[i] = (ones == NCH);
                MODE_OR:  r[i] = (ones != 0);
                MODE_XOR: r[i] = ones[0];
                MODE_MAJ: r[i] = (ones > (NCH / 2));
                default:  r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    logic              s1_v_q, s1_v_d;
    logic [NCH*DW-1:0] s1_data_q, s1_data_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic              s2_v_q, s2_v_d;
    logic [DW-1:0]     s2_data_q, s2_data_d;
    logic              s2_take_s, s1_take_s, in_xfer_s, s1_adv_s;

    // Ready chain and next-state for both stages; data registers only move on a transfer or advance.
    always_comb begin
        s2_take_s = !s2_v_q || out_ready;
        s1_take_s = !s1_v_q || s2_take_s;
        in_xfer_s = in_valid && s1_take_s;
        s1_adv_s  = s1_v_q && s2_take_s;

        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        s1_mode_d = s1_mode_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;

        if (in_xfer_s) begin
            s1_v_d    = 1'b1;
            s1_data_d = in_data;
            s1_mode_d = in_mode;
        end else if (s1_adv_s) begin
            s1_v_d    = 1'b0;
        end else begin
            s1_v_d    = s1_v_q;
        end

        if (s1_adv_s) begin
            s2_v_d    = 1'b1;
            s2_data_d = lf_eval(s1_data_q, s1_mode_q);
        end else begin
            s2_v_d    = s2_v_q && !out_ready;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_mode_q <= 2'b00;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_data_q <= s1_data_d;
            s1_mode_q <= s1_mode_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
        end
    end

    assign in_ready  = s1_take_s;
    assign out_valid = s2_v_q;
    assign out_data  = s2_data_q;

`ifdef LFP_STAT_EN
    logic [CNTW-1:0] cnt_q, cnt_d;

    // Saturating count of output transfers.
    always_comb begin
        cnt_d = cnt_q;
        if (s2_v_q && out_ready && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Statistics counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_logic_func_pipe.sv
// Randomised plus directed bench for logic_func_pipe with a queue-based reference model.
module tb_logic_func_pipe;

    localparam int CNTW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = 24'h0;
    logic [1:0]  in_mode = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [31:0] in_data4 = 32'h0;
    logic [1:0]  in_mode4 = 2'b11;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic [7:0]  out_data4;

`ifdef LFP_STAT_EN
    logic [CNTW-1:0] stat_cnt;
    logic [CNTW-1:0] stat_cnt4;
`endif

    logic_func_pipe #(.DW(8), .NCH(3), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
`ifdef LFP_STAT_EN
        , .stat_cnt(stat_cnt)
`endif
    );

    logic_func_pipe #(.DW(8), .NCH(4), .CNTW(CNTW)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .in_mode(in_mode4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_data(out_data4)
`ifdef LFP_STAT_EN
        , .stat_cnt(stat_cnt4)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         e;
    } ent_t;

    ent_t q[$];
    int   stat_m = 0;
    int   errors = 0;
    int   checks = 0;

    // Reference: word-level reductions for AND/OR/XOR, explicit ones count for MAJ.
    function automatic logic [7:0] model(input logic [23:0] d, input logic [1:0] m);
        logic [7:0] c0, c1, c2, r;
        int         n;
        c0 = d[7:0];
        c1 = d[15:8];
        c2 = d[23:16];
        r  = 8'h00;
        if (m == 2'b00) r = c0 & c1 & c2;
        else if (m == 2'b01) r = c0 | c1 | c2;
        else if (m == 2'b10) r = c0 ^ c1 ^ c2;
        else begin
            for (int b = 0; b < 8; b++) begin
                n = int'(c0[b]) + int'(c1[b]) + int'(c2[b]);
                r[b] = (n >= 2);
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One cycle: drive inputs, compare DUT with model, then advance the model across the next edge.
    task automatic step(input logic v, input logic [23:0] d, input logic [1:0] m,
                        input logic ordy, input logic lit_en, input logic [7:0] lit);
        logic ev, er;
        @(negedge clk);
        in_valid  = v;
        in_data   = v ? d : 24'hxxxxxx;
        in_mode   = m;
        out_ready = ordy;
        #1;
        ev = (q.size() > 0) && (cyc >= q[0].e + 1);
        er = (q.size() < 2) || ordy;
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("in_ready", {31'd0, in_ready}, {31'd0, er});
        if (ev) chk("out_data", {24'd0, out_data}, {24'd0, q[0].d});
        if (lit_en) begin
            chk("lit_valid", {31'd0, out_valid}, 32'd1);
            chk("lit_data", {24'd0, out_data}, {24'd0, lit});
        end
`ifdef LFP_STAT_EN
        chk("stat_cnt", {28'd0, stat_cnt}, stat_m);
`endif
        if (ev && ordy) begin
            void'(q.pop_front());
            if (stat_m < 15) stat_m++;
        end
        if (v && er) q.push_back('{model(d, m), cyc + 1});
    endtask

    // Single beat with no back-pressure; the literal result must be present 2 edges later.
    task automatic lit_test(input logic [23:0] d, input logic [1:0] m, input logic [7:0] lit);
        step(1'b1, d, m, 1'b1, 1'b0, 8'h00);
        step(1'b0, 24'h0, 2'b00, 1'b1, 1'b0, 8'h00);
        step(1'b0, 24'h0, 2'b00, 1'b1, 1'b1, lit);
        step(1'b0, 24'h0, 2'b00, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic maj4(input logic [31:0] d, input logic [7:0] lit);
        @(negedge clk);
        in_valid4 = 1'b1;
        in_data4  = d;
        @(negedge clk);
        in_valid4 = 1'b0;
        in_data4  = 32'hxxxxxxxx;
        @(negedge clk);
        #1;
        chk("maj4_valid", {31'd0, out_valid4}, 32'd1);
        chk("maj4_data", {24'd0, out_data4}, {24'd0, lit});
    endtask

    initial begin
        logic [23:0] rd;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        maj4({8'h03, 8'h03, 8'h00, 8'h00}, 8'h00);
        maj4({8'h03, 8'h03, 8'h03, 8'h00}, 8'h03);

        lit_test({8'h0F, 8'h3C, 8'hFF}, 2'b00, 8'h0C);
        lit_test({8'h0F, 8'h3C, 8'hFF}, 2'b01, 8'hFF);
        lit_test({8'h0F, 8'h3C, 8'hFF}, 2'b10, 8'hCC);
        lit_test({8'h00, 8'h00, 8'h01}, 2'b11, 8'h00);
        lit_test({8'h00, 8'h01, 8'h01}, 2'b11, 8'h01);

        // Back-pressure: third beat waits, head result holds.
        for (int i = 0; i < 4; i++) step(1'b1, {8'h0F, 8'h3C, 8'hFF}, 2'b00, 1'b0, 1'b0, 8'h00);
        step(1'b1, {8'h0F, 8'h3C, 8'hFF}, 2'b00, 1'b0, 1'b1, 8'h0C);
        for (int i = 0; i < 5; i++) step(1'b0, 24'h0, 2'b00, 1'b1, 1'b0, 8'h00);

        // Streaming with per-beat mode change and toggling out_ready.
        for (int i = 0; i < 8; i++) begin
            rd = 24'($urandom);
            step(1'b1, rd, 2'(i % 4), 1'(i % 2), 1'b0, 8'h00);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 24'h0, 2'b00, 1'b1, 1'b0, 8'h00);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            rd = 24'($urandom);
            step(1'($urandom_range(0, 3) != 0), rd, 2'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'b0, 8'h00);
        end
`ifdef LFP_STAT_EN
        chk("stat_sat", {28'd0, stat_cnt}, 32'd15);
`endif

        // Reset with both stages full.
        step(1'b1, 24'h123456, 2'b01, 1'b0, 1'b0, 8'h00);
        step(1'b1, 24'h654321, 2'b10, 1'b0, 1'b0, 8'h00);
        step(1'b1, 24'hABCDEF, 2'b11, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data", {24'd0, out_data}, 32'd0);
`ifdef LFP_STAT_EN
        chk("midrst_stat", {28'd0, stat_cnt}, 32'd0);
`endif
        q.delete();
        stat_m = 0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 24'h0, 2'b00, 1'b1, 1'b0, 8'h00);
        lit_test({8'h0F, 8'h3C, 8'hFF}, 2'b10, 8'hCC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
